// File: rtl/addressable_fifo_reader.sv
// -----------------------------------------------------------------------------
// addressable_fifo_reader
//
// Read-side controller for the addressable shift buffer in the UART datapath.
// The buffer shifts every entry up by one on each write strobe (newest word at
// entry 0), so the oldest unfetched word always sits at (occupancy - 1). This
// block tracks that occupancy from the write strobe, addresses the oldest word,
// captures the buffer's registered output and presents it on a valid/ready
// stream in arrival order.
//
// Build option:
//   FIFO_READER_OVF_EN  - when defined, a sticky overflow flag records that an
//                         unread word was pushed out of a full buffer. When not
//                         defined, overflow is tied low and has no register;
//                         count saturation and word loss behave the same.
// -----------------------------------------------------------------------------
module addressable_fifo_reader #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wea,
    input  logic          clr,
    output logic [AW-1:0] fifo_addr,
    input  logic [DW-1:0] fifo_dout,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [AW:0]   count,
    output logic          overflow
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FETCH = 2'b01,
        ST_VALID = 2'b10
    } state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] ZERO_C  = {(AW+1){1'b0}};

    state_t          state_r;
    state_t          state_next_s;
    logic [AW:0]     count_r;
    logic [AW:0]     count_next_s;
    logic [AW:0]     eff_s;
    logic [AW:0]     eff_m1_s;
    logic            full_s;
    logic            issue_s;
    logic [AW-1:0]   fifo_addr_s;
    logic [DW-1:0]   m_data_r;
    logic [DW-1:0]   m_data_next_s;
    logic            m_valid_r;
    logic            m_valid_next_s;

    // Occupancy as seen by a read this cycle: a write lands before the read,
    // but the buffer never holds more than DEPTH unread words.
    always_comb begin
        full_s = (count_r == DEPTH_C);
        if (full_s) begin
            eff_s = DEPTH_C;
        end else begin
            eff_s = count_r + {{AW{1'b0}}, wea};
        end
        eff_m1_s = eff_s - ONE_C;
    end

    // Start a fetch when a word is available and the output slot is free or
    // being freed by a handshake; a clear cycle never fetches.
    always_comb begin
        issue_s = 1'b0;
        if (clr) begin
            issue_s = 1'b0;
        end else if (eff_s == ZERO_C) begin
            issue_s = 1'b0;
        end else begin
            case (state_r)
                ST_EMPTY: issue_s = 1'b1;
                ST_VALID: issue_s = m_ready;
                ST_FETCH: issue_s = 1'b0;
                default:  issue_s = 1'b0;
            endcase
        end
    end

    // Oldest unfetched word lives at eff-1; park the address at 0 when idle.
    always_comb begin
        fifo_addr_s = {AW{1'b0}};
        if (issue_s) begin
            fifo_addr_s = eff_m1_s[AW-1:0];
        end else begin
            fifo_addr_s = {AW{1'b0}};
        end
    end

    assign fifo_addr = fifo_addr_s;

    // Unfetched-word count: grows with writes (saturating), shrinks per fetch.
    always_comb begin
        count_next_s = count_r;
        if (clr) begin
            count_next_s = ZERO_C;
        end else if (issue_s) begin
            count_next_s = eff_s - ONE_C;
        end else begin
            count_next_s = eff_s;
        end
    end

    // Reader state sequencing: EMPTY -> FETCH -> VALID -> (FETCH | EMPTY).
    always_comb begin
        state_next_s = state_r;
        if (clr) begin
            state_next_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (issue_s) begin
                        state_next_s = ST_FETCH;
                    end else begin
                        state_next_s = ST_EMPTY;
                    end
                end
                ST_FETCH: begin
                    state_next_s = ST_VALID;
                end
                ST_VALID: begin
                    if (!m_ready) begin
                        state_next_s = ST_VALID;
                    end else if (issue_s) begin
                        state_next_s = ST_FETCH;
                    end else begin
                        state_next_s = ST_EMPTY;
                    end
                end
                default: begin
                    state_next_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Output word capture: load the buffer output only in the fetch cycle,
    // otherwise (including clear) keep the presented word stable.
    always_comb begin
        m_data_next_s = m_data_r;
        if (clr) begin
            m_data_next_s = m_data_r;
        end else if (state_r == ST_FETCH) begin
            m_data_next_s = fifo_dout;
        end else begin
            m_data_next_s = m_data_r;
        end
        m_valid_next_s = (state_next_s == ST_VALID);
    end

    // State and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_EMPTY;
            count_r <= ZERO_C;
        end else begin
            state_r <= state_next_s;
            count_r <= count_next_s;
        end
    end

    // Registered stream outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_data_r  <= {DW{1'b0}};
            m_valid_r <= 1'b0;
        end else begin
            m_data_r  <= m_data_next_s;
            m_valid_r <= m_valid_next_s;
        end
    end

    assign m_data  = m_data_r;
    assign m_valid = m_valid_r;
    assign count   = count_r;

`ifdef FIFO_READER_OVF_EN
    logic overflow_r;
    logic overflow_next_s;

    // Sticky loss flag: a write into a full buffer pushes out an unread word.
    always_comb begin
        overflow_next_s = overflow_r;
        if (clr) begin
            overflow_next_s = 1'b0;
        end else if (wea && full_s) begin
            overflow_next_s = 1'b1;
        end else begin
            overflow_next_s = overflow_r;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_next_s;
        end
    end

    assign overflow = overflow_r;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_addressable_fifo_reader.sv
// -----------------------------------------------------------------------------
// Bench for addressable_fifo_reader. A behavioural shift buffer sits on the
// read port; a queue-based model of the unread words predicts the stream.
// -----------------------------------------------------------------------------
module tb_addressable_fifo_reader;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          wea;
    logic          clr;
    logic          m_ready;
    logic [DW-1:0] wdat;
    logic [AW-1:0] fifo_addr;
    logic [DW-1:0] fifo_dout;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic [AW:0]   count;
    logic          overflow;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    addressable_fifo_reader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wea       (wea),
        .clr       (clr),
        .fifo_addr (fifo_addr),
        .fifo_dout (fifo_dout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .count     (count),
        .overflow  (overflow)
    );

    // Attached shift buffer: write shifts up and loads entry 0, and a read in
    // the same cycle sees the post-shift contents, registered one cycle later.
    logic [DW-1:0] bufm [DEPTH];

    initial begin
        for (int i = 0; i < DEPTH; i++) bufm[i] = '0;
        fifo_dout = '0;
    end

    always @(posedge clk) begin
        if (wea) begin
            bufm[0] <= wdat;
            for (int i = 1; i < DEPTH; i++) bufm[i] <= bufm[i-1];
            if (fifo_addr == '0) fifo_dout <= wdat;
            else                 fifo_dout <= bufm[int'(fifo_addr) - 1];
        end else begin
            fifo_dout <= bufm[fifo_addr];
        end
    end

    // Reference model: queue of unfetched words, oldest at the front.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] outq[$];
    int            mst;      // 0 empty, 1 fetching, 2 holding a word
    logic [DW-1:0] mpend;
    logic [DW-1:0] mdata;
    logic          movf;

    task automatic model_reset();
        mq.delete();
        mst   = 0;
        mpend = '0;
        mdata = '0;
        movf  = 1'b0;
    endtask

    task automatic model_step(input logic w, input logic [DW-1:0] d,
                              input logic r, input logic c);
        bit iss;
        if (c) begin
            mq.delete();
            mst  = 0;
            movf = 1'b0;
            return;
        end
        if (w) begin
            mq.push_back(d);
            if (mq.size() > DEPTH) begin
                void'(mq.pop_front());
                movf = 1'b1;
            end
        end
        iss = (mq.size() > 0) && (mst == 0 || (mst == 2 && r));
        if (mst == 1) begin
            mdata = mpend;
            mst   = 2;
        end else if (iss) begin
            mpend = mq.pop_front();
            mst   = 1;
        end else if (mst == 2 && r) begin
            mst = 0;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_ovf(input logic v);
`ifdef FIFO_READER_OVF_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    // Per-cycle comparison of every DUT output against the model.
    task automatic compare_all();
        chk("m_valid",  m_valid,  (mst == 2));
        chk("m_data",   m_data,   mdata);
        chk("count",    count,    mq.size());
        chk("overflow", overflow, exp_ovf(movf));
    endtask

    // One clock cycle: check outputs, apply inputs, advance model and DUT.
    task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        compare_all();
        wea     = w;
        wdat    = d;
        m_ready = r;
        clr     = c;
        if (m_valid && r && !c) outq.push_back(m_data);
        model_step(w, d, r, c);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; wea = 1'b0; clr = 1'b0; m_ready = 1'b0; wdat = '0;
        model_reset();
        #1;
        chk("rst m_valid",   m_valid,   1'b0);
        chk("rst m_data",    m_data,    32'h0);
        chk("rst count",     count,     6'd0);
        chk("rst overflow",  overflow,  1'b0);
        chk("rst fifo_addr", fifo_addr, 5'd0);
        @(negedge clk);
        rst = 1'b1;

        // Single word, consumer ready.
        outq.delete();
        cyc(1'b1, 32'hA5A50001, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t1 m_valid", m_valid, 1'b1);
        chk("t1 m_data",  m_data,  32'hA5A50001);
        chk("t1 count",   count,   6'd0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("t1 m_valid after", m_valid, 1'b0);

        // Back-pressure then drain.
        outq.delete();
        cyc(1'b1, 32'd1, 1'b0, 1'b0);
        cyc(1'b1, 32'd2, 1'b0, 1'b0);
        cyc(1'b1, 32'd3, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 1'b0, 1'b0);
        chk("t2 m_data held", m_data, 32'd1);
        chk("t2 count",       count,  6'd2);
        for (int i = 0; i < 8; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0);
        chk("t2 out size", outq.size(), 3);
        for (int i = 0; i < 3 && i < outq.size(); i++) chk("t2 out word", outq[i], i + 1);
        chk("t2 count end", count, 6'd0);

        // Continuous writes overlapping fetch and handshake cycles.
        outq.delete();
        for (int i = 0; i < 10; i++) cyc(1'b1, 32'(10 + i), 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0);
        chk("t3 out size", outq.size(), 10);
        for (int i = 0; i < 10 && i < outq.size(); i++) chk("t3 out word", outq[i], 10 + i);

        // Fill past capacity with the consumer stalled.
        outq.delete();
        for (int i = 1; i <= 34; i++) begin
            cyc(1'b1, 32'(i), 1'b0, 1'b0);
            if (i == 33) begin
                chk("t4 count full",   count,    6'd32);
                chk("t4 no overflow",  overflow, 1'b0);
            end
            if (i == 34) begin
                chk("t4 count sat", count, 6'd32);
`ifdef FIFO_READER_OVF_EN
                chk("t4 overflow", overflow, 1'b1);
`else
                chk("t4 overflow", overflow, 1'b0);
`endif
            end
        end
        for (int i = 0; i < 80; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0);
        chk("t4 out size", outq.size(), 33);
        for (int i = 0; i < 33 && i < outq.size(); i++)
            chk("t4 out word", outq[i], (i == 0) ? 1 : i + 2);

        // Clear with a simultaneous write.
        outq.delete();
        cyc(1'b1, 32'd7,  1'b0, 1'b0);
        cyc(1'b1, 32'd8,  1'b0, 1'b0);
        cyc(1'b1, 32'd9,  1'b0, 1'b0);
        cyc(1'b1, 32'd10, 1'b0, 1'b0);
        cyc(1'b0, 32'd0,  1'b0, 1'b0);
        chk("t5 pre m_valid", m_valid, 1'b1);
        chk("t5 pre count",   count,   6'd3);
        cyc(1'b1, 32'd99, 1'b0, 1'b1);
        chk("t5 clr m_valid",  m_valid,  1'b0);
        chk("t5 clr count",    count,    6'd0);
        chk("t5 clr overflow", overflow, 1'b0);
        chk("t5 clr m_data",   m_data,   32'd7);
        cyc(1'b1, 32'h55, 1'b1, 1'b0);
        cyc(1'b0, 32'h0,  1'b1, 1'b0);
        chk("t5 m_valid", m_valid, 1'b1);
        chk("t5 m_data",  m_data,  32'h55);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a fetch.
        cyc(1'b1, 32'hAA, 1'b0, 1'b0);
        cyc(1'b1, 32'hBB, 1'b0, 1'b0);
        cyc(1'b1, 32'hCC, 1'b0, 1'b0);
        cyc(1'b0, 32'h0,  1'b1, 1'b0);
        chk("t6 pre count",  count,  6'd1);
        chk("t6 pre m_data", m_data, 32'hAA);
        #2 rst = 1'b0;
        #1;
        chk("t6 async m_valid",  m_valid,  1'b0);
        chk("t6 async m_data",   m_data,   32'h0);
        chk("t6 async count",    count,    6'd0);
        chk("t6 async overflow", overflow, 1'b0);
        model_reset();
        wea = 1'b0; m_ready = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        cyc(1'b1, 32'h5A, 1'b1, 1'b0);
        cyc(1'b0, 32'h0,  1'b1, 1'b0);
        chk("t6 post m_valid", m_valid, 1'b1);
        chk("t6 post m_data",  m_data,  32'h5A);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // Randomised traffic in blocks with varying write/ready pressure.
        for (int blk = 0; blk < 16; blk++) begin
            int wp;
            int rp;
            wp = $urandom_range(15, 95);
            rp = (blk % 4 == 1) ? 0 : $urandom_range(10, 100);
            for (int n = 0; n < 150; n++) begin
                cyc(($urandom_range(0, 99) < wp) ? 1'b1 : 1'b0,
                    $urandom(),
                    ($urandom_range(0, 99) < rp) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
            end
        end
        for (int i = 0; i < 80; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0);
        compare_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/addressable_fifo_reader.md
# addressable_fifo_reader

Read-side controller for the 32-entry addressable shift buffer in the UART datapath. It tracks the number of unread words in the buffer using the buffer's write strobe. It generates the read address of the oldest unread word and captures the buffer's registered output. Words are presented in arrival order on a valid/ready stream toward the UART transmit/processor side.

## Interface
Parameters:
- DEPTH, 32, number of entries in the attached buffer (power of two)
- AW, 5, buffer address width, log2(DEPTH)
- DW, 32, data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- wea  in  1  same strobe that writes the buffer; each high cycle shifts one word into entry 0
- clr  in  1  synchronous clear of reader state, highest priority after reset
- fifo_addr  out  AW  read address to the buffer (combinational)
- fifo_dout  in  DW  buffer output, registered one cycle after fifo_addr
- m_data  out  DW  output word (registered)
- m_valid  out  1  m_data holds a word
- m_ready  in  1  consumer accepts m_data when m_valid & m_ready
- count  out  AW+1  words in the buffer not yet fetched (0..DEPTH)
- overflow  out  1  sticky: an unread word was shifted out of the buffer

## Operation
- Buffer semantics: a write shifts entry i to i+1 and loads entry 0. A read in the same cycle as a write returns the post-shift contents. Newest word is at 0; oldest unfetched word is at eff-1.
- eff = min(count + wea, DEPTH).
- States:
  - EMPTY: m_valid=0.
  - FETCH: fifo_dout is the requested word.
  - VALID: m_valid=1.
- issue = (eff > 0) & ((state==EMPTY) | (state==VALID & m_ready)).
- On issue: fifo_addr = eff-1 (low AW bits). Otherwise fifo_addr = 0.
- count_next = eff - issue.
- Transitions:
  - EMPTY: to FETCH on issue, else stay.
  - FETCH: always to VALID, with m_data <= fifo_dout.
  - VALID: if m_ready and issue, to FETCH. If m_ready and no issue, to EMPTY. If not m_ready, stay; m_data stays stable.
- Writes during FETCH or VALID do not disturb the captured word. Fetch ordering is maintained solely through count.
- Overflow: a write with count==DEPTH shifts the oldest unread word out. That word is lost, count saturates at DEPTH, and overflow is set. This holds even if issue occurs the same cycle; the fetch then returns the next oldest word.
- clr: state<=EMPTY, count<=0, m_valid<=0, overflow<=0; m_data is held. A wea in the clr cycle is discarded.

## Timing
- Reset values: state EMPTY, count 0, m_valid 0, m_data 0, overflow 0, fifo_addr 0 (no issue possible while count 0 and wea 0).
- Latency: wea in cycle t with state EMPTY leads to m_valid high in cycle t+2.
- Throughput: one word per 2 cycles with m_ready held high.
- m_valid deasserts only after a handshake, clr, or reset.
- Reset asserted mid-operation forces all outputs to reset values immediately, without waiting for clk.

## Configuration
- FIFO_READER_OVF_EN defined: overflow flag implemented as above.
- FIFO_READER_OVF_EN not defined: overflow is tied to 0 and its register is removed. Count saturation and word-loss behaviour are unchanged.

## Test plan
- Reset, write 0xA5A50001 in cycle 0, m_ready=1 -> m_valid=1 with m_data=0xA5A50001 in cycle 2, count=0 throughout, then m_valid=0.
- Write 1,2,3 on consecutive cycles with m_ready=0 -> m_data=1 held, count=2. Then m_ready=1 -> words 2 and 3 out in order, one every 2 cycles, count=0.
- Continuous writes 10..19 with m_ready=1, including writes coinciding with FETCH and handshake cycles -> output sequence exactly 10..19, no duplicates or gaps.
- m_ready=0, write 1..34 -> count=32 after word 33. Word 34 sets overflow=1 (0 with macro undefined). Drain yields 1,3,4,...,34.
- Three words pending with m_valid=1, pulse clr with a simultaneous wea -> m_valid=0, count=0, overflow=0. Next write 0x55 -> m_data=0x55 two cycles later.
- Assert rst low between clk edges during FETCH -> m_valid=0, m_data=0, count=0 immediately. After release, a single write is delivered normally.
